// File: rtl/fft_frame_pkg.sv
// Shared sizing, FSM encoding and buffer addressing for the FFT input framer.
// Default geometry: 128 new samples per 256-point zero-padded frame.
package fft_frame_pkg;
  localparam int DW = 16;
  localparam int N  = 256;
  localparam int L  = 128;
  localparam int AW = $clog2(2 * L);
  localparam int BW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, DATA, ZERO} state_t;

  // Ping-pong address: half A occupies 0..L-1, half B occupies L..2L-1.
  function automatic logic [AW-1:0] buf_addr(input logic half, input logic [AW-1:0] idx);
    return half ? AW'(L) + idx : idx;
  endfunction
endpackage

// File: rtl/fft_in_buf.sv
// Ping-pong sample store: simple dual-port RAM, 2*L x DW, registered read (latency 1).
// The read register holds its value while re is low, which gives the framer its stall.
module fft_in_buf
  import fft_frame_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2*L];

  // NOTE: no reset on the array or its read register, so the block maps onto block RAM;
  // a reset here would force it into fabric registers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_frame_in.sv
// Input-side framer: packs each block of L samples into an N-beat zero-padded frame
// and streams it to the forward FFT core's Avalon-ST sink with full backpressure.
module fft_frame_in
  import fft_frame_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          din_en,
  input  logic [DW-1:0] din,
  input  logic          sink_ready,
  output logic          sink_valid,
  output logic          sink_sop,
  output logic          sink_eop,
  output logic [DW-1:0] sink_real,
  output logic [DW-1:0] sink_imag,
  output logic [1:0]    sink_error,
  output logic          inverse,
  output logic          ovf
);
  state_t        state, state_d;
  logic [AW-1:0] wcnt;
  logic          wr_half, rd_half;
  logic          wrap, blk_done;
  logic [BW-1:0] beat_cnt;
  logic          last_data, last_beat, adv;
  logic          re, load_beat;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] rdata, beat_data;

  assign sink_imag  = '0;
  assign sink_error = 2'b00;
  assign inverse    = 1'b0;

  // A block is accepted only when the reader is idle; a dropped block keeps the writer
  // on the same half, so the half being read is never overwritten.
  assign wrap      = din_en && (wcnt == AW'(L - 1));
  assign blk_done  = wrap && (state == IDLE);
  assign waddr     = buf_addr(wr_half, wcnt);
  assign last_data = (beat_cnt == BW'(L - 1));
  assign last_beat = (beat_cnt == BW'(N - 1));
  assign adv       = !sink_valid || sink_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= '0;
      wr_half <= 1'b0;
      ovf     <= 1'b0;
    end else if (din_en) begin
      wcnt <= wrap ? '0 : wcnt + AW'(1);
      if (blk_done)                 wr_half <= ~wr_half;
      if (wrap && (state != IDLE))  ovf     <= 1'b1;
    end
  end

  fft_in_buf u_buf (
    .clk   (clk),
    .we    (din_en),
    .waddr (waddr),
    .wdata (din),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    re        = 1'b0;
    raddr     = buf_addr(rd_half, '0);
    load_beat = 1'b0;
    beat_data = '0;
    unique case (state)
      IDLE: if (blk_done) state_d = LOAD;
      LOAD: begin
        re      = 1'b1;
        state_d = DATA;
      end
      DATA: if (adv) begin
        // rdata holds beat beat_cnt; prefetch the next sample of the block.
        load_beat = 1'b1;
        beat_data = rdata;
        re        = !last_data;
        raddr     = buf_addr(rd_half, AW'(beat_cnt) + AW'(1));
        if (last_beat)      state_d = IDLE;
        else if (last_data) state_d = ZERO;
      end
      ZERO: if (adv) begin
        load_beat = 1'b1;
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_half    <= 1'b0;
      beat_cnt   <= '0;
      sink_valid <= 1'b0;
      sink_sop   <= 1'b0;
      sink_eop   <= 1'b0;
      sink_real  <= '0;
    end else begin
      if (blk_done) rd_half <= wr_half;
      if (load_beat) begin
        sink_valid <= 1'b1;
        sink_real  <= beat_data;
        sink_sop   <= (beat_cnt == '0);
        sink_eop   <= last_beat;
        beat_cnt   <= last_beat ? '0 : beat_cnt + BW'(1);
      end else if (sink_ready) begin
        sink_valid <= 1'b0;
        sink_sop   <= 1'b0;
        sink_eop   <= 1'b0;
      end
    end
  end
endmodule
